// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU) driving a shared external ALU.
// Optional macro MULDIV_BYPASS_EN adds zero/one-operand fast paths; divide-by-zero is always fast.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out
);
    localparam int CW = $clog2(ITER);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_t;

    if (WIDTH != 32 || ITER != WIDTH) begin : g_param_check
        $error("muldiv_seq supports only WIDTH = ITER = 32");
    end

    state_t           state, state_next;
    logic [CW-1:0]    counter;
    logic [1:0]       op_q;
    // acc holds hi (multiply) or rem (divide); shreg holds lo or quo; opnd is mcand or dsr.
    logic [WIDTH-1:0] acc, shreg, opnd;
    logic [WIDTH-1:0] sh, fast_acc, fast_shreg;
    logic             accept, fast, last_iter, is_div, carry, take;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && req_ready;
    assign is_div     = op_q[1];
    assign last_iter  = (counter == CW'(ITER - 1));
    assign result     = op_q[0] ? acc : shreg;
    assign sh         = {acc[WIDTH-2:0], shreg[WIDTH-1]};
    assign carry      = (alu_out < alu_a);
    assign take       = acc[WIDTH-1] || (sh >= opnd);

    // Fast-path detection and the final register contents it loads directly.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fast       = 1'b0;
        fast_acc   = '0;
        fast_shreg = '0;
        case (op)
            OP_DIVU: begin
                if (rs2 == '0) begin
                    fast       = 1'b1;
                    fast_shreg = '1;
                end
`ifdef MULDIV_BYPASS_EN
                else if (rs2 == WIDTH'(1)) begin
                    fast       = 1'b1;
                    fast_shreg = rs1;
                end
`endif
            end
            OP_REMU: begin
                if (rs2 == '0) begin
                    fast     = 1'b1;
                    fast_acc = rs1;
                end
`ifdef MULDIV_BYPASS_EN
                else if (rs2 == WIDTH'(1)) begin
                    fast = 1'b1;
                end
`endif
            end
            default: begin
`ifdef MULDIV_BYPASS_EN
                fast = (rs1 == '0) || (rs2 == '0);
`endif
            end
        endcase
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (state == CALC) begin
            if (is_div) begin
                alu_a    = sh;
                alu_b    = opnd;
                alu_ctrl = ALU_SUB;
            end else begin
                alu_a = acc;
                alu_b = shreg[0] ? opnd : '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? DONE : CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            op_q    <= '0;
            acc     <= '0;
            shreg   <= '0;
            opnd    <= '0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            counter <= '0;
            op_q    <= op;
            if (fast) begin
                acc   <= fast_acc;
                shreg <= fast_shreg;
                opnd  <= '0;
            end else begin
                acc   <= '0;
                shreg <= op[1] ? rs1 : rs2;
                opnd  <= op[1] ? rs2 : rs1;
            end
        end else if (state == CALC) begin
            counter <= counter + 1'b1;
            if (is_div) begin
                acc   <= take ? alu_out : sh;
                shreg <= {shreg[WIDTH-2:0], take};
            end else begin
                acc   <= {carry, alu_out[WIDTH-1:1]};
                shreg <= {alu_out[0], shreg[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized ops against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        resp_valid, resp_ready;
    logic [31:0] result;
    logic        busy;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;

    int n_vec  = 0;
    int n_miss = 0;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .rs1(rs1), .rs2(rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result(result), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
    );

    // External ALU: ADD or SUB only.
    assign alu_out = (alu_ctrl == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit f;
        f = o[1] && (b == 0);
`ifdef MULDIV_BYPASS_EN
        if (!o[1] && (a == 0 || b == 0)) f = 1'b1;
        if (o[1] && b == 1) f = 1'b1;
`endif
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_alu"}, {alu_ctrl, alu_a[13:0], alu_b[13:0]} | 32'(|{alu_a, alu_b}), 32'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          exp_lat, lat;
        bit          bad_alu, bad_hold;
        exp     = ref_result(o, a, b);
        exp_lat = ref_fast(o, a, b) ? 1 : 33;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; req_valid = 1'b1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0;
        bad_alu = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (busy && !resp_valid && alu_ctrl !== (o[1] ? 4'b0001 : 4'b0000)) bad_alu = 1'b1;
        end while (!resp_valid && lat < 100);
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", result, exp);
        check("alu_ctrl_calc", 32'(bad_alu), 32'd0);
        bad_hold = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || result !== exp || req_ready !== 1'b0) bad_hold = 1'b1;
        end
        if (hold > 0) check("hold_stable", 32'(bad_hold), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("idle_after_resp", {30'd0, req_ready, resp_valid}, 32'b10);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        op = '0; rs1 = '0; rs2 = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(2'd0, 32'd7, 32'd6, 0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        do_op(2'd2, 32'd100, 32'd7, 0);
        do_op(2'd3, 32'd100, 32'd7, 0);
        do_op(2'd2, 32'h8000_0000, 32'd3, 0);
        do_op(2'd2, 32'd5, 32'd0, 0);
        do_op(2'd3, 32'd5, 32'd0, 2);
        do_op(2'd2, 32'd100, 32'd7, 5);
        do_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        do_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 0);

        // Abort a MUL ten cycles into CALC with an asynchronous reset.
        @(negedge clk);
        op = 2'd0; rs1 = 32'h1234_5677; rs2 = 32'h0F0F_0F0F; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'd0, 32'd3, 32'd4, 0);

        for (int n = 0; n < 30; n++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0:       ;
                1:       b = 32'd0;
                2:       b = 32'd1;
                3:       a = 32'd0;
                default: b = 32'($urandom_range(2, 300));
            endcase
            do_op(o, a, b, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
